// File: rtl/button_bank_ctrl_pkg.sv
// Shared types and helpers for the button bank front end.
// State encoding, counter width helper and default timing constants.
// Optional auto-repeat is enabled by defining BUTTON_BANK_REPEAT_EN.
package btn_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_e;

    localparam int DEB_LIMIT_DEF     = 4;
    localparam int LONG_LIMIT_DEF    = 20;
    localparam int REPEAT_PERIOD_DEF = 8;

    // Bits needed to hold 0..limit-1, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/button_bank_ctrl_channel.sv
// One button channel: synchroniser, debouncer, press/release strobes and
// long-press / auto-repeat FSM. Auto-repeat exists only when
// BUTTON_BANK_REPEAT_EN is defined; otherwise repeat_o is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | debounced level low, nothing being timed
// PRESSED | debounced level high, timing towards the long-press mark
// LONG    | long press reported; timing repeat period (if enabled)
module btn_channel
    import btn_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_LIMIT     = DEB_LIMIT_DEF,
    parameter int LONG_LIMIT    = LONG_LIMIT_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DEB_W    = $clog2(DEB_LIMIT) + 1;
    localparam int HOLD_MAX = (LONG_LIMIT > REPEAT_PERIOD) ? LONG_LIMIT : REPEAT_PERIOD;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_LIMIT - 1);
    localparam logic [HOLD_W-1:0] LONG_TC = HOLD_W'(LONG_LIMIT - 1);
`ifdef BUTTON_BANK_REPEAT_EN
    localparam logic [HOLD_W-1:0] RPT_TC  = HOLD_W'(REPEAT_PERIOD - 1);
`endif

    logic                   btn_in;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   deb_flip;
    logic                   deb_rise;
    logic                   deb_fall;
    logic                   press_q;
    logic                   release_q;
    btn_state_e             state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   long_q;
`ifdef BUTTON_BANK_REPEAT_EN
    logic                   repeat_q;
`endif

    // Inversion sits ahead of the synchroniser so reset (all zeros) means unpressed.
    assign btn_in = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;
    assign s      = sync_q[SYNC_STAGES-1];

    // The level flips on the edge that sees the DEB_LIMIT-th disagreeing sample.
    assign deb_flip = (s != level_q) && (deb_cnt == DEB_TC);
    assign deb_rise = deb_flip && !level_q;
    assign deb_fall = deb_flip &&  level_q;

    // Input synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Debouncer plus press/release strobes aligned with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            deb_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= deb_rise;
            release_q <= deb_fall;
            if (s == level_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TC) begin
                level_q <= ~level_q;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Hold-time FSM; a release on the same edge beats long/repeat strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            long_q   <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            long_q <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
            repeat_q <= 1'b0;
`endif
            if (deb_fall) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hold_cnt <= '0;
                        if (deb_rise) begin
                            state <= PRESSED;
                        end
                    end
                    PRESSED: begin
                        if (hold_cnt == LONG_TC) begin
                            long_q   <= 1'b1;
                            state    <= LONG;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    LONG: begin
`ifdef BUTTON_BANK_REPEAT_EN
                        if (hold_cnt == RPT_TC) begin
                            repeat_q <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
`else
                        hold_cnt <= '0;
`endif
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
`ifdef BUTTON_BANK_REPEAT_EN
    assign repeat_o  = repeat_q;
`else
    assign repeat_o  = 1'b0;
`endif

endmodule

// File: rtl/button_bank_ctrl.sv
// Multi-channel button front end: NUM_BTN independent btn_channel copies
// with their per-channel outputs gathered into bit vectors.
// Auto-repeat is compiled in when BUTTON_BANK_REPEAT_EN is defined.
module button_bank_ctrl
    import btn_bank_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_LIMIT     = DEB_LIMIT_DEF,
    parameter int LONG_LIMIT    = LONG_LIMIT_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic [NUM_BTN-1:0] repeat_o
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEB_LIMIT     (DEB_LIMIT),
            .LONG_LIMIT    (LONG_LIMIT),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_i     (btn_i[g]),
            .level_o   (level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .long_o    (long_o[g]),
            .repeat_o  (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_button_bank_ctrl.sv
// Self-checking bench for button_bank_ctrl at default parameters.
module tb_button_bank_ctrl;

`ifdef BUTTON_BANK_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] level_o, press_o, release_o, long_o, repeat_o;

    int n_cmp = 0;
    int n_err = 0;

    button_bank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn),
        .level_o   (level_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0] btn;
        logic [3:0] lvl, prs, rel, lng, rpt;
    } vec_t;

    vec_t vecs[24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive channel ch high for `hold` edges from an idle channel and check its
    // outputs on every edge. Edge 1 is the first edge after the press is applied.
    task automatic press_seq(input int ch, input int hold, input int edges, input string tag);
        int rel_e;
        logic [4:0] exp;
        rel_e = hold + 6;
        for (int e = 1; e <= edges; e++) begin
            btn[ch] = (e <= hold);
            tick();
            exp[4] = (e >= 6) && (e < rel_e);
            exp[3] = (e == 6);
            exp[2] = (e == rel_e);
            exp[1] = (e == 26) && (e < rel_e);
            exp[0] = REP && (e > 26) && (e < rel_e) && (((e - 26) % 8) == 0);
            check($sformatf("%s ch%0d edge%0d", tag, ch, e),
                  {27'd0, level_o[ch], press_o[ch], release_o[ch], long_o[ch], repeat_o[ch]},
                  {27'd0, exp});
        end
        btn[ch] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;

        // Hand-derived table: ch0 steps high before edge 1, level at edge 6,
        // released before edge 18 -> falls at edge 23. ch1 has a 3-cycle glitch.
        for (int i = 0; i < 24; i++) begin
            vecs[i].btn = (i < 17) ? 4'b0001 : 4'b0000;
            if (i >= 7 && i <= 9) vecs[i].btn = vecs[i].btn | 4'b0010;
            vecs[i].lvl = (i >= 5 && i < 22) ? 4'b0001 : 4'b0000;
            vecs[i].prs = (i == 5)  ? 4'b0001 : 4'b0000;
            vecs[i].rel = (i == 22) ? 4'b0001 : 4'b0000;
            vecs[i].lng = 4'b0000;
            vecs[i].rpt = 4'b0000;
        end

        repeat (3) tick();
        check("reset_hold", {12'd0, level_o, press_o, release_o, long_o, repeat_o}, 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_20", {12'd0, level_o, press_o, release_o, long_o, repeat_o}, 32'd0);
        check("idle_level", {28'd0, level_o}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            btn = vecs[i].btn;
            tick();
            check($sformatf("vec%0d", i),
                  {12'd0, level_o, press_o, release_o, long_o, repeat_o},
                  {12'd0, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng, vecs[i].rpt});
        end
        repeat (5) tick();

        // Long press with repeats (when compiled in) and release 6 edges after fall.
        press_seq(2, 40, 52, "long");
        repeat (8) tick();

        // ch3 release lands on its long edge; ch0 presses independently meanwhile.
        fork
            press_seq(3, 20, 32, "collide");
            begin
                repeat (2) tick();
                press_seq(0, 10, 24, "indep");
            end
        join
        repeat (8) tick();

        // Re-press of ch3 must start fresh from IDLE.
        press_seq(3, 30, 40, "repress");
        repeat (8) tick();

        // Asynchronous reset while ch1 sits in LONG.
        btn[1] = 1'b1;
        repeat (30) tick();
        check("rst_pre_level", {31'd0, level_o[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {12'd0, level_o, press_o, release_o, long_o, repeat_o}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("rst_repress edge%0d", e),
                  {28'd0, level_o[1], press_o[1], long_o[1], release_o[1]},
                  {28'd0, (e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0, 1'b0, 1'b0});
        end
        btn[1] = 1'b0;
        repeat (10) tick();
        check("final_idle", {12'd0, level_o, press_o, release_o, long_o, repeat_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_bank_ctrl.md
Name: button_bank_ctrl

Overview:
- Parametrised multi-channel button front end that replaces the single-button synchroniser, debouncer and pulse chain.
- Conditions NUM_BTN raw pad inputs. Each channel gets a synchroniser, a debouncer, press/release edge pulses and long-press detection.
- Sits between the ui_in pins and the display/mode logic (seg7 driver, pattern changer).
- Outputs are single-cycle strobes plus a stable level per channel.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (min 2).
- DEB_LIMIT, 4, consecutive disagreeing synchronised samples required to flip the debounced level (min 1).
- LONG_LIMIT, 20, clock cycles a debounced press must persist before long_o fires (min 2).
- REPEAT_PERIOD, 8, cycles between auto-repeat strobes (optional feature only, min 1).
- ACTIVE_LOW, 0, 1 = raw input low means pressed; inversion applied before the synchroniser.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- btn_i, input, NUM_BTN, raw asynchronous button pads.
- level_o, output, NUM_BTN, debounced pressed level.
- press_o, output, NUM_BTN, 1-cycle strobe on debounced press.
- release_o, output, NUM_BTN, 1-cycle strobe on debounced release.
- long_o, output, NUM_BTN, 1-cycle strobe when a press reaches LONG_LIMIT.
- repeat_o, output, NUM_BTN, 1-cycle auto-repeat strobe; constant 0 when the feature is compiled out.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - all synchroniser flops clear to the unpressed value;
  - counters clear to 0; FSM goes to IDLE;
  - all outputs are 0.
- Channels are fully independent; no shared state between them.
- Synchroniser: btn_i (after ACTIVE_LOW inversion) passes through SYNC_STAGES flops, giving s.
- Debouncer: deb_cnt is clog2(DEB_LIMIT)+1 bits wide.
  - If s == level, deb_cnt clears to 0.
  - Otherwise deb_cnt increments.
  - When s != level and deb_cnt == DEB_LIMIT-1: level toggles and deb_cnt clears, both on that edge.
- Latency: a clean step on btn_i set up before edge 1 makes level_o change at edge SYNC_STAGES+DEB_LIMIT (edge 6 at defaults).
- Any excursion shorter than DEB_LIMIT synchronised samples is filtered out entirely.
- press_o / release_o are registered. They assert on the same edge that level_o rises/falls and stay high for exactly 1 cycle.
- FSM per channel; hold_cnt is clog2(max(LONG_LIMIT,REPEAT_PERIOD)) bits wide.
  - IDLE: on level rise → PRESSED, hold_cnt=0.
  - PRESSED: hold_cnt increments each cycle. When hold_cnt == LONG_LIMIT-1 → long_o pulses, state → LONG, hold_cnt=0. Net effect: long_o fires LONG_LIMIT edges after press_o.
  - LONG: hold_cnt counts the repeat period (feature enabled), otherwise holds at 0.
  - Any state: on level fall → IDLE, hold_cnt=0.
- Simultaneous events: a release on the same edge that long_o or repeat_o would fire takes priority. Only release_o is asserted; the FSM goes to IDLE.
- Re-press after release always starts fresh from IDLE.
- Reset mid-press: on rst_n release the channel reports unpressed. If the pad is still held, a new press_o follows after the full sync+debounce latency.

Optional Feature:
- Macro: BUTTON_BANK_REPEAT_EN.
- Defined: in LONG, hold_cnt increments. At hold_cnt == REPEAT_PERIOD-1, repeat_o pulses for 1 cycle and hold_cnt clears. The first repeat comes REPEAT_PERIOD edges after long_o; repeats continue until release.
- Undefined: repeat_o tied to 0, REPEAT_PERIOD unused, no repeat counter logic synthesised.

Decomposition:
- Package btn_bank_pkg holds:
  - the FSM state encoding typedef (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2);
  - a clog2-based width helper function;
  - default constants for DEB_LIMIT, LONG_LIMIT and REPEAT_PERIOD.
- Sub-module btn_channel implements one full channel (sync, debounce, FSM).
- button_bank_ctrl is a generate loop instantiating NUM_BTN copies of btn_channel and concatenating their outputs.

Test Plan (defaults, REPEAT_PERIOD=8):
- Reset, all btn_i=0 for 20 cycles → all outputs 0; level_o=4'b0000.
- btn_i[0] steps 0→1 before edge 1 → level_o[0] and press_o[0] rise at edge 6; press_o[0] is high for exactly 1 cycle.
- 3-cycle glitch on btn_i[1] → no change on level_o, press_o or release_o.
- Hold btn_i[2] for 40 cycles:
  - long_o[2] fires 20 edges after press_o[2].
  - With BUTTON_BANK_REPEAT_EN: repeat_o[2] fires at +8 and +16 after long_o[2].
  - Without the macro: repeat_o stays 0.
  - release_o[2] fires 6 edges after btn_i[2] falls.
- Hold btn_i[3] so its release lands on the long_o edge → only release_o[3] is asserted, FSM returns to IDLE; independent presses on btn_i[0] during the test are unaffected.
- Pull rst_n low while btn_i[1] is held in LONG → all outputs are 0 immediately (asynchronously). After rst_n rises with the pad still held, press_o[1] fires 6 edges later.
